// File: rtl/exec_stage_mc.sv
// Execute stage: ID/EX register, forwarding, ALU with NZCV, condition check,
// iterative MUL/MLA unit and EX/MEM register.
module exec_stage_mc #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              valid_d,
  input  logic              pcsrc_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic              memwrite_d,
  input  logic              alusrc_d,
  input  logic              is_mul_d,
  input  logic              mla_d,
  input  logic [1:0]        flagwrite_d,
  input  logic [3:0]        alu_ctrl_d,
  input  logic [3:0]        cond_d,
  input  logic [ADDR_W-1:0] waddr_d,
  input  logic [WIDTH-1:0]  rd1_d,
  input  logic [WIDTH-1:0]  rd2_d,
  input  logic [WIDTH-1:0]  ra_d,
  input  logic [WIDTH-1:0]  ext_d,
  input  logic [1:0]        fwd_a_e,
  input  logic [1:0]        fwd_b_e,
  input  logic [WIDTH-1:0]  result_w,
  output logic              busy_e,
  output logic [3:0]        flags,
  output logic              valid_m,
  output logic              pcsrc_m,
  output logic              regwrite_m,
  output logic              memtoreg_m,
  output logic              memwrite_m,
  output logic [WIDTH-1:0]  alu_result_m,
  output logic [WIDTH-1:0]  write_data_m,
  output logic [ADDR_W-1:0] waddr_m
);

  localparam int unsigned N     = WIDTH / MUL_STEP;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic              valid_e, pcsrc_e, regwrite_e, memtoreg_e, memwrite_e;
  logic              alusrc_e, is_mul_e, mla_e;
  logic [1:0]        flagwrite_e;
  logic [3:0]        alu_ctrl_e, cond_e;
  logic [ADDR_W-1:0] waddr_e;
  logic [WIDTH-1:0]  rd1_e, rd2_e, ra_e, ext_e;

  logic [WIDTH-1:0]  opa, opb, rd2f, alu_res, mul_res, res_e;
  logic [WIDTH:0]    sum;
  logic              alu_c, alu_v, pass_raw, cond_pass;
  logic              mul_start, exmem_bubble;

  logic [1:0]        state, next_state;
  logic [CNT_W-1:0]  count;
  logic [WIDTH-1:0]  acc, mul_a, mul_b, mul_ra;

  // Low MUL_STEP bits of b times a, truncated to WIDTH
  function automatic logic [WIDTH-1:0] pp(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] s;
    s = '0;
    s[MUL_STEP-1:0] = b[MUL_STEP-1:0];
    return a * s;
  endfunction

  // ID/EX register
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      valid_e <= 1'b0; pcsrc_e <= 1'b0; regwrite_e <= 1'b0; memtoreg_e <= 1'b0;
      memwrite_e <= 1'b0; alusrc_e <= 1'b0; is_mul_e <= 1'b0; mla_e <= 1'b0;
      flagwrite_e <= '0; alu_ctrl_e <= '0; cond_e <= '0; waddr_e <= '0;
      rd1_e <= '0; rd2_e <= '0; ra_e <= '0; ext_e <= '0;
    end else if (!stall_e) begin
      valid_e <= valid_d; pcsrc_e <= pcsrc_d; regwrite_e <= regwrite_d;
      memtoreg_e <= memtoreg_d; memwrite_e <= memwrite_d; alusrc_e <= alusrc_d;
      is_mul_e <= is_mul_d; mla_e <= mla_d; flagwrite_e <= flagwrite_d;
      alu_ctrl_e <= alu_ctrl_d; cond_e <= cond_d; waddr_e <= waddr_d;
      rd1_e <= rd1_d; rd2_e <= rd2_d; ra_e <= ra_d; ext_e <= ext_d;
    end
  end

  // Operand forwarding
  always_comb begin
    case (fwd_a_e)
      2'b01:   opa = result_w;
      2'b10:   opa = alu_result_m;
      default: opa = rd1_e;
    endcase
    case (fwd_b_e)
      2'b01:   rd2f = result_w;
      2'b10:   rd2f = alu_result_m;
      default: rd2f = rd2_e;
    endcase
    opb = alusrc_e ? ext_e : rd2f;
  end

  // ALU; SUB is a + ~b + 1 so C means "no borrow"
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_ctrl_e)
      4'd0: begin
        sum     = {1'b0, opa} + {1'b0, opb};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      4'd1: begin
        sum     = {1'b0, opa} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      4'd2:    alu_res = opa & opb;
      4'd3:    alu_res = opa | opb;
      4'd4:    alu_res = opa ^ opb;
      4'd5:    alu_res = opb;
      default: alu_res = '0;
    endcase
  end

  // ARM condition table on the architectural flags {N,Z,C,V}
  always_comb begin
    pass_raw = 1'b0;
    case (cond_e)
      4'h0: pass_raw = flags[2];
      4'h1: pass_raw = !flags[2];
      4'h2: pass_raw = flags[1];
      4'h3: pass_raw = !flags[1];
      4'h4: pass_raw = flags[3];
      4'h5: pass_raw = !flags[3];
      4'h6: pass_raw = flags[0];
      4'h7: pass_raw = !flags[0];
      4'h8: pass_raw = flags[1] && !flags[2];
      4'h9: pass_raw = !flags[1] || flags[2];
      4'hA: pass_raw = (flags[3] == flags[0]);
      4'hB: pass_raw = (flags[3] != flags[0]);
      4'hC: pass_raw = !flags[2] && (flags[3] == flags[0]);
      4'hD: pass_raw = flags[2] || (flags[3] != flags[0]);
      default: pass_raw = 1'b1;
    endcase
    cond_pass = valid_e && pass_raw;
  end

  assign mul_start = (state == S_IDLE) && valid_e && is_mul_e && !flush_e;
  assign busy_e    = mul_start || (state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (mul_start) next_state = (N == 1) ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush_e)                   next_state = S_IDLE;
        else if (count == CNT_W'(1))   next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Slice 0 is accumulated on the entry cycle, so busy_e spans exactly N cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0; mul_a <= '0; mul_b <= '0; mul_ra <= '0; count <= '0;
    end else if (mul_start) begin
      acc    <= pp(opa, rd2f);
      mul_a  <= opa << MUL_STEP;
      mul_b  <= rd2f >> MUL_STEP;
      mul_ra <= ra_e;
      count  <= CNT_W'(N - 1);
    end else if (state == S_RUN) begin
      acc   <= acc + pp(mul_a, mul_b);
      mul_a <= mul_a << MUL_STEP;
      mul_b <= mul_b >> MUL_STEP;
      count <= count - CNT_W'(1);
    end
  end

  assign mul_res      = acc + (mla_e ? mul_ra : '0);
  assign res_e        = (state == S_DONE) ? mul_res : alu_res;
  assign exmem_bubble = busy_e || (valid_e && is_mul_e && state == S_IDLE)
                        || ((state == S_DONE) && flush_e);

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_m <= 1'b0; pcsrc_m <= 1'b0; regwrite_m <= 1'b0; memtoreg_m <= 1'b0;
      memwrite_m <= 1'b0; alu_result_m <= '0; write_data_m <= '0; waddr_m <= '0;
    end else if (exmem_bubble) begin
      valid_m <= 1'b0; pcsrc_m <= 1'b0; regwrite_m <= 1'b0;
      memtoreg_m <= 1'b0; memwrite_m <= 1'b0;
    end else begin
      valid_m      <= valid_e;
      pcsrc_m      <= pcsrc_e && cond_pass;
      regwrite_m   <= regwrite_e && cond_pass;
      memwrite_m   <= memwrite_e && cond_pass;
      memtoreg_m   <= memtoreg_e;
      alu_result_m <= res_e;
      write_data_m <= rd2f;
      waddr_m      <= waddr_e;
    end
  end

  // Flags change only as an instruction leaves EX; multiplies keep C and V
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else if (!exmem_bubble && cond_pass) begin
      if (flagwrite_e[1]) flags[3:2] <= {res_e[WIDTH-1], (res_e == '0)};
      if (flagwrite_e[0] && (state != S_DONE)) flags[1:0] <= {alu_c, alu_v};
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Scoreboard bench for exec_stage_mc (WIDTH=32, MUL_STEP=8).
module tb_exec_stage_mc;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e, valid_d, pcsrc_d, regwrite_d, memtoreg_d;
  logic        memwrite_d, alusrc_d, is_mul_d, mla_d;
  logic [1:0]  flagwrite_d, fwd_a_e, fwd_b_e;
  logic [3:0]  alu_ctrl_d, cond_d, waddr_d;
  logic [31:0] rd1_d, rd2_d, ra_d, ext_d, result_w;
  logic        busy_e, valid_m, pcsrc_m, regwrite_m, memtoreg_m, memwrite_m;
  logic [3:0]  flags, waddr_m;
  logic [31:0] alu_result_m, write_data_m;

  exec_stage_mc #(.WIDTH(32), .MUL_STEP(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .pcsrc_d(pcsrc_d), .regwrite_d(regwrite_d),
    .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d), .alusrc_d(alusrc_d),
    .is_mul_d(is_mul_d), .mla_d(mla_d), .flagwrite_d(flagwrite_d),
    .alu_ctrl_d(alu_ctrl_d), .cond_d(cond_d), .waddr_d(waddr_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .ra_d(ra_d), .ext_d(ext_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .result_w(result_w),
    .busy_e(busy_e), .flags(flags), .valid_m(valid_m), .pcsrc_m(pcsrc_m),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .waddr_m(waddr_m)
  );

  always #5 clk = ~clk;
  assign stall_e = busy_e;  // hazard unit

  typedef struct {
    logic v, rw, src, mul, mla, psh;
    logic [3:0] alu, cond, wa;
    logic [1:0] fw, fa, fb;
    logic [31:0] a, b, ra, ext, resw, x_res;
    logic x_rw;
    logic [3:0] x_fl;
  } ins_t;

  typedef struct {
    logic [31:0] res;
    logic rw;
    logic [3:0] wa, fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  ins_t pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ins_t alu_op(input logic [3:0] alu, input logic [3:0] cond,
                                  input logic [1:0] fw, input logic [3:0] wa,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] xres, input logic xrw,
                                  input logic [3:0] xfl);
    ins_t t;
    t = '{v: 1'b1, rw: 1'b1, src: 1'b0, mul: 1'b0, mla: 1'b0, psh: 1'b1,
          alu: alu, cond: cond, wa: wa, fw: fw, fa: 2'b00, fb: 2'b00,
          a: a, b: b, ra: 32'h0, ext: 32'h0, resw: 32'h0, x_res: xres,
          x_rw: xrw, x_fl: xfl};
    return t;
  endfunction

  task automatic drive_dec(input ins_t t);
    valid_d = t.v; pcsrc_d = 1'b0; regwrite_d = t.rw; memtoreg_d = 1'b0;
    memwrite_d = 1'b0; alusrc_d = t.src; is_mul_d = t.mul; mla_d = t.mla;
    flagwrite_d = t.fw; alu_ctrl_d = t.alu; cond_d = t.cond; waddr_d = t.wa;
    rd1_d = t.a; rd2_d = t.b; ra_d = t.ra; ext_d = t.ext;
  endtask

  // Present t at decode, give the EX-resident instruction its forwarding,
  // and hold t until the stage accepts it; w = cycles spent stalled.
  task automatic issue(input ins_t t, output int w);
    @(negedge clk);
    drive_dec(t);
    fwd_a_e = pend.fa; fwd_b_e = pend.fb; result_w = pend.resw;
    if (t.v && t.psh) sb.push_back('{res: t.x_res, rw: t.x_rw, wa: t.wa, fl: t.x_fl});
    w = 0;
    while (stall_e && w < 20) begin
      @(posedge clk);
      @(negedge clk);
      w++;
      fwd_a_e = 2'($urandom); fwd_b_e = 2'($urandom); result_w = $urandom;
    end
    if (stall_e) check("stall_timeout", 32'(w), 32'd0);
    pend = t;
    @(posedge clk);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && valid_m === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_m", 32'(valid_m), 32'd0);
      end else begin
        e = sb.pop_front();
        check("alu_result_m", alu_result_m, e.res);
        check("regwrite_m", 32'(regwrite_m), 32'(e.rw));
        check("waddr_m", 32'(waddr_m), 32'(e.wa));
        check("flags", 32'(flags), 32'(e.fl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t nop, t;
    int w;
    nop = alu_op(4'd0, 4'hE, 2'b00, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0);
    nop.v = 1'b0;
    pend = nop;
    reset = 1'b1; flush_e = 1'b0; fwd_a_e = 2'b00; fwd_b_e = 2'b00; result_w = '0;
    drive_dec(nop);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_e), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_valid_m", 32'(valid_m), 32'd0);
    check("rst_alu_result_m", alu_result_m, 32'd0);
    check("rst_write_data_m", write_data_m, 32'd0);
    reset = 1'b0;

    // ADD overflow, SUB to zero, then EQ/NE predicated ADDs
    issue(alu_op(4'd0, 4'hE, 2'b11, 4'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 4'b1001), w);
    issue(alu_op(4'd1, 4'hE, 2'b10, 4'd2, 32'h5, 32'h5, 32'h0, 1'b1, 4'b0101), w);
    issue(alu_op(4'd0, 4'h0, 2'b00, 4'd3, 32'h1, 32'h2, 32'h3, 1'b1, 4'b0101), w);
    issue(alu_op(4'd0, 4'h1, 2'b11, 4'd4, 32'h1, 32'h2, 32'h3, 1'b0, 4'b0101), w);

    // Forwarding from M and from W with immediate operand
    issue(alu_op(4'd0, 4'hE, 2'b00, 4'd5, 32'h10, 32'h0, 32'h10, 1'b1, 4'b0101), w);
    t = alu_op(4'd0, 4'hE, 2'b00, 4'd6, 32'h0, 32'h99, 32'h13, 1'b1, 4'b0101);
    t.src = 1'b1; t.ext = 32'h3; t.fa = 2'b10;
    issue(t, w);
    t = alu_op(4'd0, 4'hE, 2'b00, 4'd7, 32'h0, 32'h99, 32'h23, 1'b1, 4'b0101);
    t.src = 1'b1; t.ext = 32'h3; t.fa = 2'b01; t.resw = 32'h20;
    issue(t, w);

    // Logic ops and more condition codes
    issue(alu_op(4'd5, 4'hB, 2'b11, 4'd8, 32'h0, 32'h55, 32'h55, 1'b1, 4'b0000), w);
    issue(alu_op(4'd2, 4'hC, 2'b00, 4'd9, 32'hF0F0, 32'hFF00, 32'hF000, 1'b1, 4'b0000), w);
    issue(alu_op(4'd3, 4'h8, 2'b11, 4'd10, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 4'b0000), w);
    issue(alu_op(4'd4, 4'h9, 2'b00, 4'd11, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b1, 4'b0000), w);
    issue(alu_op(4'd7, 4'hE, 2'b10, 4'd12, 32'h1, 32'h2, 32'h0, 1'b1, 4'b0100), w);

    // Back-to-back MUL then MLA; forwarding selects toggle during RUN
    t = alu_op(4'd0, 4'hE, 2'b00, 4'd13, 32'h0001_0003, 32'h5, 32'h0005_000F, 1'b1, 4'b0100);
    t.mul = 1'b1;
    issue(t, w);
    t = alu_op(4'd0, 4'hE, 2'b00, 4'd14, 32'h0001_0003, 32'h5, 32'h0005_0010, 1'b1, 4'b0100);
    t.mul = 1'b1; t.mla = 1'b1; t.ra = 32'h1;
    issue(t, w);
    check("mul_busy_cycles", 32'(w), 32'd4);
    issue(nop, w);
    check("mla_busy_cycles", 32'(w), 32'd4);

    // Carry/borrow, then MULS keeping C and V
    issue(alu_op(4'd1, 4'hE, 2'b11, 4'd1, 32'h5, 32'h3, 32'h2, 1'b1, 4'b0010), w);
    issue(alu_op(4'd1, 4'hE, 2'b11, 4'd2, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b1, 4'b1000), w);
    issue(alu_op(4'd0, 4'hE, 2'b11, 4'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'b0011), w);
    t = alu_op(4'd0, 4'hE, 2'b11, 4'd4, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 1'b1, 4'b1011);
    t.mul = 1'b1;
    issue(t, w);
    issue(nop, w);
    check("muls_busy_cycles", 32'(w), 32'd4);
    issue(nop, w);
    issue(nop, w);

    // Flush in the second busy cycle aborts the multiply
    t = alu_op(4'd0, 4'hE, 2'b11, 4'd9, 32'h3, 32'h3, 32'h0, 1'b1, 4'h0);
    t.mul = 1'b1; t.psh = 1'b0;
    issue(t, w);
    @(negedge clk);
    drive_dec(nop); fwd_a_e = 2'b00; fwd_b_e = 2'b00;
    check("flush_entry_busy", 32'(busy_e), 32'd1);
    @(negedge clk);
    flush_e = 1'b1;
    @(negedge clk);
    flush_e = 1'b0;
    check("flush_busy_after", 32'(busy_e), 32'd0);
    check("flush_flags", 32'(flags), 32'b1011);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_valid_m", 32'(valid_m), 32'd0);
    end
    check("flush_flags_late", 32'(flags), 32'b1011);
    pend = nop;

    // Reset mid-multiply
    issue(t, w);
    @(negedge clk);
    drive_dec(nop); fwd_a_e = 2'b00; fwd_b_e = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_busy", 32'(busy_e), 32'd0);
    check("rst2_flags", 32'(flags), 32'd0);
    check("rst2_valid_m", 32'(valid_m), 32'd0);
    check("rst2_regwrite_m", 32'(regwrite_m), 32'd0);
    check("rst2_alu_result_m", alu_result_m, 32'd0);
    check("rst2_waddr_m", 32'(waddr_m), 32'd0);
    pend = nop;

    issue(alu_op(4'd0, 4'hE, 2'b11, 4'd5, 32'h2, 32'h3, 32'h5, 1'b1, 4'b0000), w);
    repeat (3) issue(nop, w);
    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
